// File: rtl/lsu.sv
// lsu -- RV32I load/store unit between execute and the register-file write port.
//
// Accepts one memory op per in_valid/in_ready handshake, runs a single
// req/gnt/rvalid data-memory transaction and, for loads, delivers the aligned and
// sign/zero-extended result as a one-cycle write-back pulse.
//
// Handshakes (valid/ready semantics):
//   in_valid/in_ready : an op transfers on a rising edge where both are high;
//                       in_ready is high only in IDLE with rst low.
//   mem_req/mem_gnt   : mem_req and its payload (mem_we/addr/wstrb/wdata) stay
//                       stable until a rising edge with mem_gnt high; mem_req
//                       drops the following cycle.
//   mem_rvalid        : sampled only while waiting for load data, ignored otherwise.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready/in_load/in_funct3/in_addr/in_wdata/in_rd_addr   op input
//   mem_req/mem_we/mem_addr/mem_wstrb/mem_wdata/mem_gnt/mem_rvalid/mem_rdata
//                                data-memory port
//   wb_we/wb_rd_addr/wb_rd_data  regfile write-back
//   busy                         high whenever not IDLE
//   misalign_err                 only with LSU_MISALIGN_TRAP_EN defined
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When defined, a legal op with a
// misaligned address is accepted but dropped, and misalign_err pulses for one
// cycle. When undefined, low address bits are ignored and the access proceeds at
// the naturally aligned location.
module lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_load,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [4:0]      in_rd_addr,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_we,
  output logic [4:0]      wb_rd_addr,
  output logic [XLEN-1:0] wb_rd_data,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic            misalign_err,
`endif
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;
  state_t state;

  // Op fields kept for the response phase.
  logic       op_load;
  logic [2:0] op_funct3;
  logic [1:0] op_off;
  logic [4:0] op_rd;

  function automatic logic is_legal(input logic ld, input logic [2:0] f3);
    if (ld) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                   (f3 == 3'b100) || (f3 == 3'b101);
    else    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction
`endif

  // Selects the addressed byte/halfword lane and extends it. Halfwords use only
  // off[1] and words ignore off entirely, which realises the aligned fallback.
  function automatic logic [XLEN-1:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [XLEN-1:0] rdata);
    logic [XLEN-1:0] sh_b;
    logic [XLEN-1:0] sh_h;
    sh_b = rdata >> {off, 3'b000};
    sh_h = rdata >> {off[1], 4'b0000};
    case (f3)
      3'b000:  return {{24{sh_b[7]}}, sh_b[7:0]};
      3'b100:  return {24'd0, sh_b[7:0]};
      3'b001:  return {{16{sh_h[15]}}, sh_h[15:0]};
      3'b101:  return {16'd0, sh_h[15:0]};
      default: return rdata;
    endcase
  endfunction

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_load    <= 1'b0;
      op_funct3  <= 3'b000;
      op_off     <= 2'b00;
      op_rd      <= 5'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= 4'b0000;
      mem_wdata  <= '0;
      wb_we      <= 1'b0;
      wb_rd_addr <= 5'd0;
      wb_rd_data <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
    end else begin
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_load   <= in_load;
            op_funct3 <= in_funct3;
            op_off    <= in_addr[1:0];
            op_rd     <= in_rd_addr;
            if (!is_legal(in_load, in_funct3)) begin
              state <= IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
            end else if (is_misaligned(in_funct3, in_addr[1:0])) begin
              misalign_err <= 1'b1;
              state        <= IDLE;
`endif
            end else begin
              state    <= REQ;
              mem_req  <= 1'b1;
              mem_we   <= !in_load;
              mem_addr <= {in_addr[XLEN-1:2], 2'b00};
              if (in_load) begin
                mem_wstrb <= 4'b0000;
                mem_wdata <= '0;
              end else begin
                case (in_funct3[1:0])
                  2'b00: begin
                    mem_wstrb <= 4'b0001 << in_addr[1:0];
                    mem_wdata <= {4{in_wdata[7:0]}};
                  end
                  2'b01: begin
                    mem_wstrb <= in_addr[1] ? 4'b1100 : 4'b0011;
                    mem_wdata <= {2{in_wdata[15:0]}};
                  end
                  default: begin
                    mem_wstrb <= 4'b1111;
                    mem_wdata <= in_wdata;
                  end
                endcase
              end
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= op_load ? WAIT : IDLE;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            wb_we      <= (op_rd != 5'd0);
            wb_rd_addr <= op_rd;
            wb_rd_data <= extract(op_funct3, op_off, mem_rdata);
            state      <= WB;
          end
        end
        WB: begin
          wb_we <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu -- self-checking bench for lsu: directed scenarios plus randomized ops,
// checked against a byte-lane reference model written from the ISA rules.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_load;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd_addr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_we;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;
  logic        busy;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  lsu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_rd_addr(in_rd_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_we(wb_we), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
`ifdef LSU_MISALIGN_TRAP_EN
    .misalign_err(misalign_err),
`endif
    .busy(busy)
  );

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_legal(input bit ld, input logic [2:0] f3);
    if (ld) return f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5;
    return f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2;
  endfunction

  function automatic int model_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  // Byte offset of the access inside the word, rounded down to natural alignment.
  function automatic int model_off(input logic [2:0] f3, input logic [31:0] addr);
    return int'(addr[1:0]) & ~(model_size(f3) - 1);
  endfunction

  function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    return (int'(addr[1:0]) % model_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] s;
    int off, size;
    size = model_size(f3);
    off  = model_off(f3, addr);
    for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + size);
    return s;
  endfunction

  // Every lane carries the store data byte that would land there (replication).
  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] w;
    int size;
    size = model_size(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % size) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] v, mask;
    int size;
    size = model_size(f3);
    v = rdata >> (8 * model_off(f3, addr));
    if (size < 4) begin
      mask = (32'd1 << (8 * size)) - 32'd1;
      v = v & mask;
      if (!f3[2] && v[8*size-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic do_op(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
    int n;
    logic [31:0] exp_v;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid   = 1'b1;
    in_load    = ld;
    in_funct3  = f3;
    in_addr    = addr;
    in_wdata   = wd;
    in_rd_addr = rd;
    @(negedge clk);
    in_valid = 1'b0;
    in_addr  = $urandom;
    in_wdata = $urandom;

    if (!model_legal(ld, f3)) begin
      check_eq("illegal_req", {31'd0, mem_req}, 32'd0);
      check_eq("illegal_ready", {31'd0, in_ready}, 32'd1);
      check_eq("illegal_wb", {31'd0, wb_we}, 32'd0);
      return;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    if (model_misaligned(f3, addr)) begin
      check_eq("mis_err", {31'd0, misalign_err}, 32'd1);
      check_eq("mis_req", {31'd0, mem_req}, 32'd0);
      check_eq("mis_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      check_eq("mis_err_pulse", {31'd0, misalign_err}, 32'd0);
      check_eq("mis_wb", {31'd0, wb_we}, 32'd0);
      return;
    end
    check_eq("mis_err_idle", {31'd0, misalign_err}, 32'd0);
`endif

    for (int i = 0; i <= gnt_dly; i++) begin
      check_eq("req", {31'd0, mem_req}, 32'd1);
      check_eq("req_we", {31'd0, mem_we}, {31'd0, !ld});
      check_eq("req_addr", mem_addr, {addr[31:2], 2'b00});
      check_eq("req_strb", {28'd0, mem_wstrb}, ld ? 32'd0 : {28'd0, model_strb(f3, addr)});
      if (!ld) check_eq("req_wdata", mem_wdata, model_wdata(f3, wd));
      check_eq("req_busy", {31'd0, busy}, 32'd1);
      check_eq("req_ready", {31'd0, in_ready}, 32'd0);
      if (i == gnt_dly) mem_gnt = 1'b1;
      @(negedge clk);
    end
    mem_gnt = 1'b0;
    check_eq("req_drop", {31'd0, mem_req}, 32'd0);
    if (!ld) begin
      check_eq("st_ready", {31'd0, in_ready}, 32'd1);
      check_eq("st_busy", {31'd0, busy}, 32'd0);
      check_eq("st_wb", {31'd0, wb_we}, 32'd0);
      return;
    end

    exp_q.push_back(model_load(f3, addr, rdata));
    for (int i = 0; i <= rv_dly; i++) begin
      check_eq("wait_busy", {31'd0, busy}, 32'd1);
      check_eq("wait_wb", {31'd0, wb_we}, 32'd0);
      if (i == rv_dly) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
      end
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    exp_v = exp_q.pop_front();
    check_eq("wb_we", {31'd0, wb_we}, {31'd0, rd != 5'd0});
    check_eq("wb_rd_addr", {27'd0, wb_rd_addr}, {27'd0, rd});
    check_eq("wb_rd_data", wb_rd_data, exp_v);
    check_eq("wb_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check_eq("wb_pulse", {31'd0, wb_we}, 32'd0);
    check_eq("wb_hold", wb_rd_data, exp_v);
    check_eq("ld_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req"}, {31'd0, mem_req}, 32'd0);
    check_eq({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    check_eq({tag, "_addr"}, mem_addr, 32'd0);
    check_eq({tag, "_strb"}, {28'd0, mem_wstrb}, 32'd0);
    check_eq({tag, "_wdata"}, mem_wdata, 32'd0);
    check_eq({tag, "_wb_we"}, {31'd0, wb_we}, 32'd0);
    check_eq({tag, "_wb_rd"}, {27'd0, wb_rd_addr}, 32'd0);
    check_eq({tag, "_wb_data"}, wb_rd_data, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_load = 1'b0; in_funct3 = 3'd0;
    in_addr = 32'd0; in_wdata = 32'd0; in_rd_addr = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_ready", {31'd0, in_ready}, 32'd1);

    // directed scenarios
    do_op(1'b0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0, 0, 0, 32'd0);
    do_op(1'b0, 3'b000, 32'h0000_0203, 32'h0000_00A5, 5'd0, 0, 0, 32'd0);
    do_op(1'b0, 3'b001, 32'h0000_0206, 32'h1234_5678, 5'd0, 1, 0, 32'd0);
    do_op(1'b1, 3'b000, 32'h0000_0301, 32'd0, 5'd5, 0, 0, 32'h0000_8000);
    do_op(1'b1, 3'b100, 32'h0000_0301, 32'd0, 5'd6, 0, 0, 32'h0000_8000);
    do_op(1'b1, 3'b001, 32'h0000_0402, 32'd0, 5'd9, 3, 2, 32'h1234_ABCD);
    do_op(1'b1, 3'b010, 32'h0000_0404, 32'd0, 5'd0, 0, 0, 32'h5555_AAAA);
    do_op(1'b1, 3'b011, 32'h0000_0408, 32'd0, 5'd3, 0, 0, 32'd0);
    do_op(1'b0, 3'b100, 32'h0000_0408, 32'hFFFF_FFFF, 5'd3, 0, 0, 32'd0);
    do_op(1'b1, 3'b010, 32'h0000_0102, 32'd0, 5'd4, 0, 0, 32'hCAFE_F00D);
    do_op(1'b1, 3'b101, 32'h0000_0103, 32'd0, 5'd8, 0, 1, 32'h8765_4321);

    // reset while waiting for read data, then a stale rvalid
    in_valid = 1'b1; in_load = 1'b1; in_funct3 = 3'b010;
    in_addr = 32'h0000_0500; in_rd_addr = 5'd7;
    @(negedge clk);
    in_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check_eq("rw_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check_eq("stale_ready", {31'd0, in_ready}, 32'd1);
    check_eq("stale_wb", {31'd0, wb_we}, 32'd0);
    @(negedge clk);
    check_eq("stale_wb2", {31'd0, wb_we}, 32'd0);
    check_eq("stale_busy", {31'd0, busy}, 32'd0);
    do_op(1'b1, 3'b000, 32'h0000_0600, 32'd0, 5'd12, 0, 0, 32'h0000_00FF);

    // randomized ops
    for (int k = 0; k < 80; k++) begin
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
            5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    check_eq("exp_q_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
